// File: rtl/mem_arbiter_if.sv
// Bundle between the fetch/LSU requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic [31:0]       mem_address;
  logic [31:0]       mem_write_data;
  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic [31:0]       mem_Read_data;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_Read_data,
    output i_ready, i_rvalid, i_rdata, i_err,
    output d_ready, d_rvalid, d_rdata, d_err,
    output mem_address, mem_write_data, mem_MemWrite, mem_MemRead
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_Read_data,
    input  i_ready, i_rvalid, i_rdata, i_err,
    input  d_ready, d_rvalid, d_rdata, d_err,
    input  mem_address, mem_write_data, mem_MemWrite, mem_MemRead
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data memory between instruction fetch (I)
// and load/store (D); one word transaction at a time: grant, access, respond.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_e            state_q, state_d;
  owner_e            owner_q, rr_last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              grant_i, grant_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_err;
  logic              access_ok, mem_wr, mem_rd, resp_v;

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst) begin
          if (bus.i_req && (!bus.d_req || rr_last_q == OWN_D)) grant_i = 1'b1;
          else if (bus.d_req)                                   grant_d = 1'b1;
          if (grant_i || grant_d) state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_addr = grant_d ? bus.d_addr : bus.i_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      rr_last_q <= OWN_D;
      addr_q    <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_i || grant_d) begin
        owner_q   <= grant_d ? OWN_D : OWN_I;
        rr_last_q <= grant_d ? OWN_D : OWN_I;
        addr_q    <= sel_addr;
        we_q      <= grant_d && bus.d_we;
        wdata_q   <= grant_d ? bus.d_wdata : '0;
        err_q     <= sel_err;
      end
      if (state_q == ACCESS) rdata_q <= mem_rd ? bus.mem_Read_data : '0;
    end
  end

  // Strobes and responses are gated by rst so a transaction in flight when
  // reset arrives never reaches the memory or the requester.
  assign access_ok = !rst && (state_q == ACCESS) && !err_q;
  assign mem_wr    = access_ok && we_q;
  assign mem_rd    = access_ok && !we_q;
  assign resp_v    = !rst && (state_q == RESP);

  assign bus.mem_MemWrite   = mem_wr;
  assign bus.mem_MemRead    = mem_rd;
  assign bus.mem_address    = access_ok ? 32'(addr_q) : '0;
  assign bus.mem_write_data = mem_wr ? wdata_q : '0;

  assign bus.i_ready  = grant_i;
  assign bus.d_ready  = grant_d;
  assign bus.i_rvalid = resp_v && (owner_q == OWN_I);
  assign bus.d_rvalid = resp_v && (owner_q == OWN_D);
  assign bus.i_rdata  = bus.i_rvalid ? rdata_q : '0;
  assign bus.d_rdata  = bus.d_rvalid ? rdata_q : '0;
  assign bus.i_err    = bus.i_rvalid && err_q;
  assign bus.d_err    = bus.d_rvalid && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences, and random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic clk;
  logic rst;
  logic mem_init;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned k);
    logic [7:0] b;
    b = k[7:0];
    if (k == 4) return 32'h11223344;
    return {8'hA5, b, ~b, 8'h3C};
  endfunction

  // Word-organised 1KB memory with combinational read
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned k = 0; k < 256; k++) mem[k] <= init_word(k);
    end else if (bus.mem_MemWrite) begin
      mem[bus.mem_address[9:2]] <= bus.mem_write_data;
    end
  end
  assign bus.mem_Read_data = bus.mem_MemRead ? mem[bus.mem_address[9:2]] : '0;

  typedef struct packed {
    logic        i_ready, d_ready, i_rvalid, i_err, d_rvalid, d_err, mem_we, mem_re;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  } outs_t;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    string       nm;
  } vec_t;

  int unsigned n_checks;
  int unsigned n_fail;

  function automatic outs_t sample();
    outs_t o;
    o.i_ready   = bus.i_ready;
    o.d_ready   = bus.d_ready;
    o.i_rvalid  = bus.i_rvalid;
    o.i_err     = bus.i_err;
    o.d_rvalid  = bus.d_rvalid;
    o.d_err     = bus.d_err;
    o.mem_we    = bus.mem_MemWrite;
    o.mem_re    = bus.mem_MemRead;
    o.i_rdata   = bus.i_rdata;
    o.d_rdata   = bus.d_rdata;
    o.mem_addr  = bus.mem_address;
    o.mem_wdata = bus.mem_write_data;
    return o;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("rdy=%b/%b rv=%b/%b err=%b/%b we=%b re=%b irdata=%h drdata=%h addr=%h wdata=%h",
                     o.i_ready, o.d_ready, o.i_rvalid, o.d_rvalid, o.i_err, o.d_err,
                     o.mem_we, o.mem_re, o.i_rdata, o.d_rdata, o.mem_addr, o.mem_wdata);
  endfunction

  task automatic check(input string nm, input outs_t want);
    outs_t act;
    act = sample();
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got [%s] expected [%s]", nm, $time, fmt(act), fmt(want));
    end
  endtask

  task automatic check_word(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic drive_idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    mem_init = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(negedge clk);
    check("in_reset", '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_reset", '0);
  endtask

  // One isolated transaction: ready at T, strobe at T+1, response at T+2
  task automatic do_txn(input vec_t v);
    outs_t e;
    @(posedge clk); #1;
    drive_idle();
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
    @(negedge clk);
    e = '0;
    e.i_ready = !v.is_d;
    e.d_ready = v.is_d;
    check({v.nm, "_ready"}, e);

    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    e = '0;
    if (!v.exp_err) begin
      e.mem_addr = v.addr;
      if (v.we) begin
        e.mem_we = 1'b1; e.mem_wdata = v.wdata;
      end else begin
        e.mem_re = 1'b1;
      end
    end
    check({v.nm, "_access"}, e);

    @(posedge clk); #1;
    @(negedge clk);
    e = '0;
    if (v.is_d) begin
      e.d_rvalid = 1'b1; e.d_err = v.exp_err; e.d_rdata = v.exp_rdata;
    end else begin
      e.i_rvalid = 1'b1; e.i_err = v.exp_err; e.i_rdata = v.exp_rdata;
    end
    check({v.nm, "_resp"}, e);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 15)) << 2;
      6:                return 32'($urandom_range(0, 255)) << 2;
      7:                return (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
      8:                return ($urandom_range(0, 1) == 0) ? 32'h3FC : 32'h400;
      default:          return $urandom;
    endcase
  endfunction

  vec_t vecs [9];

  // Random-phase state: requester intents and the model's view of the arbiter
  logic              i_hold, d_hold, i_got, d_got, last_was_i;
  logic [31:0]       i_a, d_a, d_wd;
  logic              d_w;
  logic [31:0]       ref_mem [256];
  int                t_grant;
  logic              t_d, t_we, t_err;
  logic [31:0]       t_addr, t_wdata, t_rdata;

  initial begin
    outs_t e;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    mem_init = 1'b0;
    drive_idle();

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'h1122_3344, "i_rd_10"};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF,  1'b0, 32'h0,         "d_st_20"};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          1'b0, 32'hDEAD_BEEF, "d_ld_20"};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0022, 32'h0,          1'b1, 32'h0,         "d_ld_misalign"};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_03FE, 32'h1234_5678,  1'b1, 32'h0,         "d_st_3fe"};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D,  1'b0, 32'h0,         "d_st_3fc"};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,          1'b0, 32'hCAFE_F00D, "i_rd_3fc"};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,          1'b1, 32'h0,         "i_rd_400"};
    vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          1'b1, 32'h0,         "d_ld_fffffffc"};

    do_reset();

    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("idle", '0);
    end

    foreach (vecs[n]) do_txn(vecs[n]);

    // Both requesters held: grants must alternate I, D, I, D
    do_reset();
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    for (int c = 0; c < 12; c++) begin
      logic own_d;
      if (c > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      own_d = ((c / 3) % 2) == 1;
      e = '0;
      case (c % 3)
        0: begin
          e.i_ready = !own_d; e.d_ready = own_d;
        end
        1: begin
          e.mem_re = 1'b1; e.mem_addr = own_d ? 32'h20 : 32'h10;
        end
        default: begin
          if (own_d) begin
            e.d_rvalid = 1'b1; e.d_rdata = init_word(8);
          end else begin
            e.i_rvalid = 1'b1; e.i_rdata = 32'h1122_3344;
          end
        end
      endcase
      check("rr_hold", e);
    end

    // Reset during the access cycle of a store must drop it entirely
    do_reset();
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678;
    @(negedge clk);
    e = '0; e.d_ready = 1'b1;
    check("rst_st_ready", e);
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_st_access", '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_st_after", '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_st_after2", '0);
    check_word("rst_st_mem40", mem[16], init_word(16));

    // Random traffic against a transaction-level model
    do_reset();
    for (int unsigned k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    i_hold = 1'b0; d_hold = 1'b0; i_got = 1'b0; d_got = 1'b0;
    last_was_i = 1'b0;
    i_a = '0; d_a = '0; d_wd = '0; d_w = 1'b0;
    t_grant = -10;
    t_d = 1'b0; t_we = 1'b0; t_err = 1'b0; t_addr = '0; t_wdata = '0; t_rdata = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int delta;
      @(posedge clk); #1;
      if (i_got) i_hold = 1'b0;
      if (d_got) d_hold = 1'b0;
      if (!i_hold && $urandom_range(0, 2) == 0) begin
        i_hold = 1'b1; i_a = rand_addr();
      end else if (i_hold && $urandom_range(0, 15) == 0) begin
        i_hold = 1'b0;
      end
      if (!d_hold && $urandom_range(0, 2) == 0) begin
        d_hold = 1'b1; d_a = rand_addr(); d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
      end else if (d_hold && $urandom_range(0, 15) == 0) begin
        d_hold = 1'b0;
      end
      bus.i_req = i_hold; bus.i_addr = i_a;
      bus.d_req = d_hold; bus.d_we = d_w; bus.d_addr = d_a; bus.d_wdata = d_wd;

      e = '0;
      i_got = 1'b0;
      d_got = 1'b0;
      delta = cyc - t_grant;
      if (delta == 1 && !t_err) begin
        e.mem_addr = t_addr;
        e.mem_we   = t_we;
        e.mem_re   = !t_we;
        e.mem_wdata = t_we ? t_wdata : '0;
      end else if (delta == 2) begin
        if (t_d) begin
          e.d_rvalid = 1'b1; e.d_err = t_err; e.d_rdata = t_rdata;
        end else begin
          e.i_rvalid = 1'b1; e.i_err = t_err; e.i_rdata = t_rdata;
        end
      end else if (delta >= 3 && (i_hold || d_hold)) begin
        longint unsigned la;
        t_d   = (i_hold && d_hold) ? last_was_i : d_hold;
        t_addr = t_d ? d_a : i_a;
        t_we  = t_d && d_w;
        t_wdata = d_wd;
        la    = longint'(t_addr);
        t_err = (la % 4 != 0) || (la + 4 > 1024);
        t_rdata = '0;
        if (!t_err && !t_we) t_rdata = ref_mem[la / 4];
        if (!t_err && t_we)  ref_mem[la / 4] = t_wdata;
        t_grant    = cyc;
        last_was_i = !t_d;
        i_got = !t_d;
        d_got = t_d;
        e.i_ready = !t_d;
        e.d_ready = t_d;
      end
      @(negedge clk);
      check("random", e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
